sm_muldiv: RTL and testbench

//  Iterative multiply/divide unit with HI/LO result registers for the schoolMIPS core (MULTU/DIVU,

---
 rtl/sm_muldiv_pkg.sv | 27 ++
 rtl/sm_muldiv_negate.sv | 15 +
 rtl/sm_muldiv.sv | 159 +++++++++++++++
 tb/tb_sm_muldiv.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sm_muldiv_pkg.sv
// Shared oper codes and FSM state encoding for sm_muldiv.
// The FIXUP state exists only when SM_MULDIV_SIGNED_EN is defined.
package sm_muldiv_pkg;

    typedef enum logic [1:0] {
        MD_MULTU = 2'd0,
        MD_DIVU  = 2'd1,
        MD_MULT  = 2'd2,
        MD_DIV   = 2'd3
    } mdOper_t;

`ifdef SM_MULDIV_SIGNED_EN
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FIXUP = 2'd2,
        ST_DONE  = 2'd3
    } mdState_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DONE  = 2'd3
    } mdState_t;
`endif

endpackage

// File: rtl/sm_muldiv_negate.sv
// Conditional two's complement used for signed operand magnitudes and result fixup.
// Only present when SM_MULDIV_SIGNED_EN is defined.
`ifdef SM_MULDIV_SIGNED_EN
module sm_muldiv_negate #(
    parameter int WIDTH = 32
) (
    input  logic             neg,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    assign dout = neg ? (~din + WIDTH'(1)) : din;

endmodule
`endif

// File: rtl/sm_muldiv.sv
// Iterative multiply/divide with HI/LO registers: shift-add MULTU, restoring DIVU, one bit per cycle.
// Define SM_MULDIV_SIGNED_EN to add MULT/DIV (magnitude datapath plus a FIXUP negation cycle).
module sm_muldiv
    import sm_muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       oper,
    input  logic [WIDTH-1:0] srcA,
    input  logic [WIDTH-1:0] srcB,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    mdState_t           state;
    logic [CNT_W-1:0]   count;
    logic               isDiv;
    logic               divReq;
    logic [WIDTH-1:0]   opM;
    logic [WIDTH-1:0]   accHi;
    logic [WIDTH-1:0]   accLo;
    logic [WIDTH-1:0]   absA;
    logic [WIDTH-1:0]   absB;
    logic [2*WIDTH-1:0] stepRes;

    // Multiply: {accHi,accLo} starts as {0, multiplier}; add multiplicand on LSB, shift right.
    function automatic logic [2*WIDTH-1:0] mulStep(input logic [WIDTH-1:0] hiV,
                                                   input logic [WIDTH-1:0] loV,
                                                   input logic [WIDTH-1:0] mcand);
        logic [WIDTH:0] sum;
        sum = {1'b0, hiV} + (loV[0] ? {1'b0, mcand} : '0);
        return {sum, loV[WIDTH-1:1]};
    endfunction

    // Divide: accHi is the partial remainder, accLo shifts dividend bits out and quotient bits in.
    // A zero divisor always "fits", which yields quotient all ones and remainder = dividend.
    function automatic logic [2*WIDTH-1:0] divStep(input logic [WIDTH-1:0] remV,
                                                   input logic [WIDTH-1:0] quoV,
                                                   input logic [WIDTH-1:0] divisor);
        logic [WIDTH:0] shifted;
        logic [WIDTH:0] diff;
        shifted = {remV, quoV[WIDTH-1]};
        diff    = shifted - {1'b0, divisor};
        if (!diff[WIDTH])
            return {diff[WIDTH-1:0], quoV[WIDTH-2:0], 1'b1};
        return {shifted[WIDTH-1:0], quoV[WIDTH-2:0], 1'b0};
    endfunction

    assign divReq  = (oper == MD_DIVU) || (oper == MD_DIV);
    assign stepRes = isDiv ? divStep(accHi, accLo, opM) : mulStep(accHi, accLo, opM);

`ifdef SM_MULDIV_SIGNED_EN
    logic               doFix;
    logic               fixProd;
    logic               fixQuo;
    logic               fixRem;
    logic [2*WIDTH-1:0] prodFix;
    logic [WIDTH-1:0]   quoFix;
    logic [WIDTH-1:0]   remFix;

    sm_muldiv_negate #(.WIDTH(WIDTH)) uAbsA (
        .neg(oper[1] & srcA[WIDTH-1]), .din(srcA), .dout(absA));
    sm_muldiv_negate #(.WIDTH(WIDTH)) uAbsB (
        .neg(oper[1] & srcB[WIDTH-1]), .din(srcB), .dout(absB));
    sm_muldiv_negate #(.WIDTH(2*WIDTH)) uFixProd (
        .neg(fixProd), .din({accHi, accLo}), .dout(prodFix));
    sm_muldiv_negate #(.WIDTH(WIDTH)) uFixQuo (
        .neg(fixQuo), .din(accLo), .dout(quoFix));
    sm_muldiv_negate #(.WIDTH(WIDTH)) uFixRem (
        .neg(fixRem), .din(accHi), .dout(remFix));
`else
    assign absA = srcA;
    assign absB = srcB;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            count <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (hi_we) hi <= wdata;
                    if (lo_we) lo <= wdata;
                    if (start) begin
                        state <= ST_RUN;
                        busy  <= 1'b1;
                        count <= '0;
                        isDiv <= divReq;
                        accHi <= '0;
                        accLo <= divReq ? absA : absB;
                        opM   <= divReq ? absB : absA;
`ifdef SM_MULDIV_SIGNED_EN
                        doFix   <= oper[1];
                        fixProd <= srcA[WIDTH-1] ^ srcB[WIDTH-1];
                        // A zero divisor keeps the all-ones quotient regardless of signs.
                        fixQuo  <= (srcA[WIDTH-1] ^ srcB[WIDTH-1]) && (srcB != '0);
                        fixRem  <= srcA[WIDTH-1];
`endif
                    end
                end
                ST_RUN: begin
                    {accHi, accLo} <= stepRes;
                    count <= count + 1'b1;
                    if (count == LAST) begin
                        count <= '0;
`ifdef SM_MULDIV_SIGNED_EN
                        if (doFix) begin
                            state <= ST_FIXUP;
                        end else begin
                            state      <= ST_DONE;
                            busy       <= 1'b0;
                            done       <= 1'b1;
                            {hi, lo}   <= stepRes;
                        end
`else
                        state    <= ST_DONE;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        {hi, lo} <= stepRes;
`endif
                    end
                end
`ifdef SM_MULDIV_SIGNED_EN
                ST_FIXUP: begin
                    state <= ST_DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    if (isDiv) begin
                        hi <= remFix;
                        lo <= quoFix;
                    end else begin
                        {hi, lo} <= prodFix;
                    end
                end
`endif
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sm_muldiv.sv
// Scoreboard bench for sm_muldiv: stimulus pushes expected results, a negedge monitor checks them.
module tb_sm_muldiv;

    localparam int WIDTH = 32;
`ifdef SM_MULDIV_SIGNED_EN
    localparam bit SIGNED_EN = 1'b1;
`else
    localparam bit SIGNED_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  oper = 2'd0;
    logic [31:0] srcA = '0;
    logic [31:0] srcB = '0;
    logic        hi_we = 1'b0;
    logic        lo_we = 1'b0;
    logic [31:0] wdata = '0;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    sm_muldiv #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .oper(oper),
        .srcA(srcA), .srcB(srcB), .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        string       name;
        logic [31:0] hi;
        logic [31:0] lo;
        int          doneCyc;
        int          busyLen;
    } exp_t;

    exp_t sb[$];
    int   nPass = 0;
    int   nTotal = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nTotal++;
        if (act === exp) nPass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Reference: plain arithmetic on the operands, as the architecture defines MULT(U)/DIV(U).
    function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        longint sa;
        longint sb2;
        logic [63:0] p;
        if (SIGNED_EN && op[1]) begin
            sa  = longint'($signed(a));
            sb2 = longint'($signed(b));
            if (!op[0]) begin
                p = 64'(sa * sb2);
                return p;
            end
            if (b == 32'd0) return {a, 32'hFFFF_FFFF};
            return {32'(sa % sb2), 32'(sa / sb2)};
        end
        if (!op[0]) return {32'd0, a} * {32'd0, b};
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
    endfunction

    function automatic int latency(input logic [1:0] op);
        return (SIGNED_EN && op[1]) ? WIDTH + 2 : WIDTH + 1;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'($urandom_range(0, 15));
            default: return 32'($urandom);
        endcase
    endfunction

    task automatic waitIdle();
        int n = 0;
        while ((busy !== 1'b0 || done !== 1'b0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check("idleTimeout", 64'(1), 64'(0));
    endtask

    task automatic waitDrain();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            check("drainTimeout", 64'(sb.size()), 64'(0));
            sb.delete();
        end
    endtask

    task automatic issue(input string name, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] expRes,
                         input logic hiWeV, input logic loWeV, input logic [31:0] wd);
        exp_t e;
        int   l;
        waitIdle();
        start = 1'b1;
        oper  = op;
        srcA  = a;
        srcB  = b;
        hi_we = hiWeV;
        lo_we = loWeV;
        wdata = wd;
        l = latency(op);
        e.name    = name;
        e.hi      = expRes[63:32];
        e.lo      = expRes[31:0];
        e.doneCyc = cyc + l;
        e.busyLen = l - 1;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
        hi_we = 1'b0;
        lo_we = 1'b0;
        srcA  = $urandom;
        srcB  = $urandom;
    endtask

    // Monitor: checks every done pulse against the head of the scoreboard.
    exp_t mon;
    int   busyRun = 0;
    bit   prevDone = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            busyRun  = 0;
            prevDone = 1'b0;
        end else begin
            if (done === 1'b1) begin
                check("donePulse", 64'(prevDone), 64'(0));
                check("busyInDone", 64'(busy), 64'(0));
                if (sb.size() == 0) begin
                    check("unexpectedDone", 64'(1), 64'(0));
                end else begin
                    mon = sb.pop_front();
                    check({mon.name, "_hi"}, 64'(hi), 64'(mon.hi));
                    check({mon.name, "_lo"}, 64'(lo), 64'(mon.lo));
                    check({mon.name, "_cyc"}, 64'(cyc), 64'(mon.doneCyc));
                    check({mon.name, "_busy"}, 64'(busyRun), 64'(mon.busyLen));
                end
                busyRun = 0;
            end else if (busy === 1'b1) begin
                busyRun++;
            end else begin
                busyRun = 0;
            end
            prevDone = (done === 1'b1);
        end
    end

    initial begin
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        int          n;

        repeat (2) @(negedge clk);
        check("rstBusy", 64'(busy), 64'(0));
        check("rstDone", 64'(done), 64'(0));
        check("rstHi", 64'(hi), 64'(0));
        check("rstLo", 64'(lo), 64'(0));
        rst_n = 1'b1;
        @(negedge clk);

        issue("multuMax", 2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 0, 0, 0);
        issue("divu100_7", 2'd1, 32'd100, 32'd7, {32'd2, 32'd14}, 0, 0, 0);
        issue("divuZero", 2'd1, 32'h1234, 32'd0, {32'h0000_1234, 32'hFFFF_FFFF}, 0, 0, 0);
        start = 1'b1; oper = 2'd0; srcA = 32'd9; srcB = 32'd9;
        @(negedge clk);
        start = 1'b0;
        waitDrain();
        waitIdle();

        hi_we = 1'b1; wdata = 32'hA5A5_A5A5;
        @(negedge clk);
        hi_we = 1'b0;
        check("mthi", 64'(hi), 64'(32'hA5A5_A5A5));
        lo_we = 1'b1; wdata = 32'h5A5A_5A5A;
        @(negedge clk);
        lo_we = 1'b0;
        check("mtlo", 64'(lo), 64'(32'h5A5A_5A5A));

        issue("mulBusyWe", 2'd0, 32'd6, 32'd7, {32'd0, 32'd42}, 0, 0, 0);
        hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        hi_we = 1'b0; lo_we = 1'b0;
        check("hiBusyWe", 64'(hi), 64'(32'hA5A5_A5A5));
        check("loBusyWe", 64'(lo), 64'(32'h5A5A_5A5A));

        n = 0;
        while (done !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("waitDone", 64'(n < 100), 64'(1));
        start = 1'b1; oper = 2'd0; srcA = 32'd7; srcB = 32'd7;
        @(negedge clk);
        start = 1'b0;
        check("startInDone", 64'(busy), 64'(0));

        issue("mulWithWe", 2'd0, 32'd3, 32'd4, {32'd0, 32'd12}, 1, 1, 32'h1357_9BDF);
        check("hiWeStart", 64'(hi), 64'(32'h1357_9BDF));
        check("loWeStart", 64'(lo), 64'(32'h1357_9BDF));
        waitDrain();

        issue("rstAbort", 2'd0, 32'd123, 32'd456, 64'd56088, 0, 0, 0);
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        sb.delete();
        @(negedge clk);
        check("abortBusy", 64'(busy), 64'(0));
        check("abortDone", 64'(done), 64'(0));
        check("abortHi", 64'(hi), 64'(0));
        check("abortLo", 64'(lo), 64'(0));
        rst_n = 1'b1;
        issue("mul3x5", 2'd0, 32'd3, 32'd5, {32'd0, 32'd15}, 0, 0, 0);

        issue("multM3x5", 2'd2, 32'hFFFF_FFFD, 32'd5,
              SIGNED_EN ? 64'hFFFF_FFFF_FFFF_FFF1 : 64'h0000_0004_FFFF_FFF1, 0, 0, 0);
        issue("divM7by2", 2'd3, 32'hFFFF_FFF9, 32'd2,
              SIGNED_EN ? 64'hFFFF_FFFF_FFFF_FFFD : {32'd1, 32'h7FFF_FFFC}, 0, 0, 0);
        issue("divMinM1", 2'd3, 32'h8000_0000, 32'hFFFF_FFFF,
              model(2'd3, 32'h8000_0000, 32'hFFFF_FFFF), 0, 0, 0);
        issue("divNegZero", 2'd3, 32'hFFFF_FF00, 32'd0, {32'hFFFF_FF00, 32'hFFFF_FFFF}, 0, 0, 0);

        for (int i = 0; i < 40; i++) begin
            op = 2'($urandom_range(0, 3));
            a  = pick();
            b  = pick();
            issue("rnd", op, a, b, model(op, a, b), 0, 0, 0);
        end
        waitDrain();
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", nPass, nTotal);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL globalTimeout: got %0d cycles expected completion", cyc);
        $fatal(1, "timeout");
    end

endmodule
